// File: rtl/word_serializer.sv
// LSB-first word serializer. Each accepted word is shifted out over WIDTH cycles.
// A new word can be accepted on the last bit's cycle, so words can run back-to-back with no gap.
module word_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             sow,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             ser_out_reg, ser_out_next;
    logic             sow_reg, sow_next;
    logic             last_reg, last_next;
    logic             busy_reg, busy_next;
    logic             transfer;

    // last_reg is registered, so in_ready depends only on r and flops, never on in_valid.
    assign in_ready = !r && (state_reg == IDLE || last_reg);
    assign transfer = in_valid && in_ready;

    assign ser_out = ser_out_reg;
    assign sow     = sow_reg;
    assign last    = last_reg;
    assign busy    = busy_reg;

    always_ff @(posedge t_clk) begin
        if (r) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            ser_out_reg <= 1'b0;
            sow_reg     <= 1'b0;
            last_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            cnt_reg     <= cnt_next;
            ser_out_reg <= ser_out_next;
            sow_reg     <= sow_next;
            last_reg    <= last_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (transfer) begin
                    state_next = SHIFT;
                    shift_next = in_data;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                if (last_reg) begin
                    if (transfer) begin
                        shift_next = in_data;
                        cnt_next   = '0;
                    end else begin
                        state_next = IDLE;
                        shift_next = '0;
                        cnt_next   = '0;
                    end
                end else begin
                    shift_next = shift_reg >> 1;
                    cnt_next   = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                shift_next = '0;
                cnt_next   = '0;
            end
        endcase

        // Outputs are precomputed from next-state values so the registered copies line up with the bit on the wire.
        busy_next    = (state_next == SHIFT);
        ser_out_next = busy_next && shift_next[0];
        sow_next     = busy_next && (cnt_next == '0);
        last_next    = busy_next && (cnt_next == LAST_CNT);
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: an 8-bit instance for the main scenarios and a 1-bit instance for the degenerate width.
`timescale 1ns/1ps
module tb_word_serializer;

    logic       t_clk = 1'b0;
    logic       r, in_valid, in_ready, ser_out, sow, last, busy;
    logic [7:0] in_data;
    logic       r1, in_valid1, in_ready1, ser_out1, sow1, last1, busy1;
    logic [0:0] in_data1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 t_clk = ~t_clk;

    word_serializer #(.WIDTH(8)) dut8 (
        .t_clk(t_clk), .r(r), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .sow(sow), .last(last), .busy(busy)
    );

    word_serializer #(.WIDTH(1)) dut1 (
        .t_clk(t_clk), .r(r1), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .ser_out(ser_out1), .sow(sow1), .last(last1), .busy(busy1)
    );

    // Advance to just after the next rising edge; outputs are sampled and inputs driven here.
    task automatic step();
        @(posedge t_clk);
        #1;
    endtask

    task automatic test_reset();
        r = 1'b1; r1 = 1'b1;
        in_valid = 1'b0; in_valid1 = 1'b0;
        in_data = 8'h00; in_data1 = 1'b0;
        step();
        step();
        n_tests++;
        if ({ser_out, sow, last, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0000", {ser_out, sow, last, busy});
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        n_tests++;
        if ({ser_out1, sow1, last1, busy1, in_ready1} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_w1: got %b required 00000", {ser_out1, sow1, last1, busy1, in_ready1});
        end
        r = 1'b0; r1 = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_single();
        logic exp_bits [8] = '{1, 0, 1, 0, 1, 1, 0, 0};
        in_data = 8'h35; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if ({ser_out, sow, last, busy} !== {exp_bits[k], k == 0, k == 7, 1'b1}) begin
                n_fail++;
                $display("FAIL single_cycle%0d: got ser/sow/last/busy=%b required %b", k + 1,
                         {ser_out, sow, last, busy}, {exp_bits[k], k == 0, k == 7, 1'b1});
            end
            step();
        end
        n_tests++;
        if ({ser_out, sow, last, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_idle: got %b required 0000", {ser_out, sow, last, busy});
        end
        $display("[TB] word 0x35 serialized");
    endtask

    task automatic test_back_to_back();
        logic exp_bits [16] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        in_data = 8'hA5; in_valid = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if ({ser_out, sow, last, busy, in_ready} !==
                {exp_bits[k], k == 0 || k == 8, k == 7 || k == 15, 1'b1, k == 7 || k == 15}) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got ser/sow/last/busy/rdy=%b required %b", k + 1,
                         {ser_out, sow, last, busy, in_ready},
                         {exp_bits[k], k == 0 || k == 8, k == 7 || k == 15, 1'b1, k == 7 || k == 15});
            end
            if (k == 7) in_data = 8'h0F;
            if (k == 15) in_valid = 1'b0;
            step();
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b required 0", busy);
        end
        $display("[TB] words 0xA5,0x0F serialized back-to-back");
    endtask

    task automatic test_ignore_while_shifting();
        in_data = 8'h00; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 8'hFF;
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if ({ser_out, sow, busy} !== {k >= 8, k == 0 || k == 8, 1'b1}) begin
                n_fail++;
                $display("FAIL ignore_cycle%0d: got ser/sow/busy=%b required %b", k + 1,
                         {ser_out, sow, busy}, {k >= 8, k == 0 || k == 8, 1'b1});
            end
            if (k >= 1 && k <= 6) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignore_ready_cycle%0d: got %b required 0", k + 1, in_ready);
                end
            end
            if (k >= 1 && k <= 7) in_valid = 1'b1;
            else in_valid = 1'b0;
            step();
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_idle: got busy=%b required 0", busy);
        end
        $display("[TB] word 0x00 then 0xFF serialized");
    endtask

    task automatic test_reset_mid_word();
        logic exp_bits [4] = '{0, 1, 0, 1};
        in_data = 8'h5A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({ser_out, busy} !== {exp_bits[k], 1'b1}) begin
                n_fail++;
                $display("FAIL midrst_cycle%0d: got ser/busy=%b required %b", k + 1,
                         {ser_out, busy}, {exp_bits[k], 1'b1});
            end
            if (k == 3) begin
                r = 1'b1;
                #1;
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midrst_ready_in_reset: got %b required 0", in_ready);
                end
            end
            step();
        end
        r = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready_after: got %b required 1", in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if ({ser_out, sow, last, busy} !== 4'b0000) begin
                n_fail++;
                $display("FAIL midrst_after%0d: got %b required 0000", k, {ser_out, sow, last, busy});
            end
            step();
        end
        $display("[TB] word 0x5A abandoned by reset");
    endtask

    task automatic test_reset_with_valid();
        logic exp_bits [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
        r = 1'b1; in_valid = 1'b1; in_data = 8'h33;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstvalid_ready: got %b required 0", in_ready);
        end
        step();
        n_tests++;
        if ({ser_out, sow, last, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstvalid_outputs: got %b required 0000", {ser_out, sow, last, busy});
        end
        r = 1'b0; in_data = 8'h96;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if ({ser_out, sow, last, busy} !== {exp_bits[k], k == 0, k == 7, 1'b1}) begin
                n_fail++;
                $display("FAIL rstvalid_cycle%0d: got %b required %b", k + 1,
                         {ser_out, sow, last, busy}, {exp_bits[k], k == 0, k == 7, 1'b1});
            end
            step();
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstvalid_idle: got busy=%b required 0", busy);
        end
        $display("[TB] word 0x33 refused in reset, 0x96 serialized");
    endtask

    task automatic test_width1();
        logic exp_bits [3] = '{1, 0, 1};
        in_valid1 = 1'b1;
        in_data1 = exp_bits[0];
        step();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({ser_out1, sow1, last1, busy1, in_ready1} !== {exp_bits[k], 4'b1111}) begin
                n_fail++;
                $display("FAIL w1_cycle%0d: got ser/sow/last/busy/rdy=%b required %b", k + 1,
                         {ser_out1, sow1, last1, busy1, in_ready1}, {exp_bits[k], 4'b1111});
            end
            if (k < 2) in_data1 = exp_bits[k + 1];
            else in_valid1 = 1'b0;
            step();
        end
        n_tests++;
        if ({ser_out1, sow1, last1, busy1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL w1_idle: got %b required 0000", {ser_out1, sow1, last1, busy1});
        end
        $display("[TB] width-1 words 1,0,1 serialized");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_while_shifting();
        test_reset_mid_word();
        test_reset_with_valid();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, number of bits per word (legal range 1..32).
REQ-002 SHALL have port: t_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: r  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: in_data  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port: in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port: in_ready  output  1  serializer accepts a word at this edge if in_valid is high.
REQ-007 SHALL have port: ser_out  output  1  serial bit, LSB first; drives the downstream serial two's-complement stage data input.
REQ-008 SHALL have port: sow  output  1  start-of-word strobe, high on the cycle the word LSB is presented; drives the downstream stage word-start input.
REQ-009 SHALL have port: last  output  1  high on the cycle the word MSB is presented.
REQ-010 SHALL have port: busy  output  1  high while a word is being shifted out.

Function
REQ-011 SHALL implement two states, IDLE and SHIFT, plus a shift register of WIDTH bits and a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-012 SHALL drive in_ready = !r && (state==IDLE || last), combinationally.
REQ-013 SHALL define transfer as in_valid && in_ready at a rising edge; only transfers load in_data.
REQ-014 SHALL, on a transfer, capture in_data, set counter to 0, enter SHIFT; ser_out = in_data[0] and sow = 1 in the following cycle (latency one cycle from accept edge to first bit).
REQ-015 SHALL, in SHIFT, present bit k of the captured word on ser_out during the cycle with counter == k, advancing one bit per edge; sow high only when counter == 0.
REQ-016 SHALL assert last when state==SHIFT and counter == WIDTH-1.
REQ-017 SHALL, at the edge ending the last cycle, load the next word with no gap if a transfer occurs (sow high in the very next cycle), else return to IDLE.
REQ-018 SHALL drive ser_out = 0, sow = 0, last = 0, busy = 0 in IDLE.
REQ-019 SHALL hold busy = 1 in every SHIFT cycle, including back-to-back words.
REQ-020 SHALL ignore in_data changes and in_valid while in SHIFT before the last cycle; in_ready is 0 there, so no word is captured or lost.
REQ-021 SHALL, for WIDTH == 1, assert sow and last together every SHIFT cycle and accept a word every cycle under continuous in_valid.
REQ-022 SHALL register ser_out, sow, last and busy so that none is a combinational function of in_valid or in_data.

Reset
REQ-023 SHALL, at a rising edge with r high, enter IDLE, clear shift register and counter; the following cycle has ser_out=0, sow=0, last=0, busy=0.
REQ-024 SHALL force in_ready = 0 while r is high, so a word offered with r high is not accepted.
REQ-025 SHALL, on reset mid-word, abandon the remaining bits; no partial bits resume after reset deasserts.
REQ-026 SHALL give all outputs defined (non-X) values from the first cycle after the first reset edge.

Verification
REQ-027 SHALL cover: WIDTH=8, reset 2 cycles, offer 0x35 one cycle -> next 8 cycles ser_out 1,0,1,0,1,1,0,0, sow only on cycle 1, last only on cycle 8, then IDLE with busy=0.
REQ-028 SHALL cover: in_valid held with 0xA5 then 0x0F presented at the last cycle -> 16 consecutive busy cycles, ser_out 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0, sow on cycles 1 and 9.
REQ-029 SHALL cover: in_valid high with 0xFF during SHIFT cycles 2..7 of word 0x00 -> in_ready=0 those cycles, 0x00 bits unaffected, 0xFF captured only at the last-cycle edge.
REQ-030 SHALL cover: r pulsed at cycle 4 of word 0x5A -> next cycle all outputs 0, in_ready=0 during r, 1 after; no further 0x5A bits appear.
REQ-031 SHALL cover: r and in_valid high together with 0x33 -> word not accepted, outputs 0, next word after r low serialized normally.
REQ-032 SHALL cover: WIDTH=1, continuous in_valid with data 1,0,1 -> ser_out 1,0,1 on consecutive cycles, sow=last=1 each cycle.
